seq_divider8: RTL and testbench

SEQ_DIVIDER8 -- requirements
Module: seq_divider8

---
 rtl/div_pkg.sv | 13 +
 rtl/full_subtractor.sv | 14 +
 rtl/seq_divider8.sv | 141 ++++++++++++++
 tb/tb_seq_divider8.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
// No timing of its own; types only.
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell (a - b - bin) for the trial-subtraction ripple chain.
// Combinational, zero latency; no flow control.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/seq_divider8.sv
// Unsigned restoring divider, one quotient bit per clock; done pulses WIDTH+1 cycles after accept
// (1 cycle for divide-by-zero). start is only honoured in IDLE, so requests during RUN/DONE are dropped.
module seq_divider8
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    div_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   dvs_ext;
    logic [WIDTH:0]   diff;
    logic [WIDTH+1:0] borrow;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] q_next;
    logic             rem_msb_unused;

    // The partial remainder never exceeds the divisor after a step, so its top bit is not shifted on.
    assign rem_msb_unused = rem_q[WIDTH];
    assign shifted        = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    assign dvs_ext        = {1'b0, dvs_q};
    assign borrow[0]      = 1'b0;

    for (genvar i = 0; i <= WIDTH; i++) begin : g_sub
        full_subtractor u_fs (
            .a    (shifted[i]),
            .b    (dvs_ext[i]),
            .bin  (borrow[i]),
            .d    (diff[i]),
            .bout (borrow[i+1])
        );
    end

    assign rem_next = borrow[WIDTH+1] ? shifted : diff;
    assign q_next   = {dvd_q[WIDTH-2:0], ~borrow[WIDTH+1]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dvd_d = dividend;
                    dvs_d = divisor;
                    rem_d = '0;
                    cnt_d = CW'(WIDTH);
                    if (divisor == '0) begin
                        state_d     = ST_DONE;
                        done_d      = 1'b1;
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        busy_d  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                dvd_d = q_next;
                rem_d = rem_next;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d     = ST_DONE;
                    done_d      = 1'b1;
                    quotient_d  = q_next;
                    remainder_d = rem_next[WIDTH-1:0];
                    dbz_d       = 1'b0;
                end else begin
                    busy_d = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider8.sv
// Randomised and directed bench for seq_divider8 against an arithmetic reference (/ and %).
module tb_seq_divider8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [7:0] divisor = '0;
    logic       busy, done, div_by_zero;
    logic [7:0] quotient, remainder;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_divider8 #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Reference: plain integer division; divisor 0 gives all ones / dividend / flag.
    function automatic void ref_div(input int a, input int b, output int q, output int r,
                                    output int z, output int lat);
        if (b == 0) begin
            q = 255; r = a; z = 1; lat = 1;
        end else begin
            q = a / b; r = a % b; z = 0; lat = 9;
        end
    endfunction

    // Issues one request from IDLE and observes the result; lat = -1 if done never came.
    task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                           output logic [7:0] q, output logic [7:0] r, output logic z,
                           output int lat, output int busy_n);
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk);
        #1;
        start = 1'b0; dividend = 8'($urandom); divisor = 8'($urandom);
        lat = -1; busy_n = 0; q = 'x; r = 'x; z = 1'bx;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                lat = n; q = quotient; r = remainder; z = div_by_zero;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, div_by_zero, quotient, remainder} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b done=%b dbz=%b q=%0d r=%0d required all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        rst = 1'b0;
    endtask

    task automatic test_case(input logic [7:0] a, input logic [7:0] b, input string name);
        logic [7:0] q, r; logic z; int lat, bn, eq, er, ez, el;
        ref_div(int'(a), int'(b), eq, er, ez, el);
        run_div(a, b, q, r, z, lat, bn);
        checks++;
        if (lat !== el || q !== 8'(eq) || r !== 8'(er) || z !== 1'(ez)) begin
            errors++;
            $display("FAIL %s %0d/%0d got q=%0d r=%0d z=%b lat=%0d required q=%0d r=%0d z=%0d lat=%0d",
                     name, a, b, q, r, z, lat, eq, er, ez, el);
        end
        checks++;
        if (bn != el - 1) begin
            errors++;
            $display("FAIL %s_busy %0d/%0d busy cycles=%0d required %0d", name, a, b, bn, el - 1);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s_single_pulse done=%b required 0", name, done);
        end
    endtask

    task automatic test_directed;
        test_case(8'd100, 8'd7, "basic_100_7");
        test_case(8'd255, 8'd1, "corner_255_1");
        test_case(8'd5, 8'd9, "corner_5_9");
        test_case(8'd255, 8'd255, "corner_255_255");
        test_case(8'd200, 8'd0, "div_zero_200");
    endtask

    task automatic test_start_ignored;
        int pulses = 0; logic [7:0] q = 'x, r = 'x;
        @(negedge clk);
        start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 25; n++) begin
            @(negedge clk);
            if (done) begin pulses++; q = quotient; r = remainder; end
            start = (n >= 1 && n <= 4);
            dividend = 8'd50; divisor = 8'd5;
        end
        start = 1'b0;
        checks++;
        if (pulses != 1 || q !== 8'd14 || r !== 8'd2) begin
            errors++;
            $display("FAIL start_ignored pulses=%0d q=%0d r=%0d required 1 pulse, 14 r 2", pulses, q, r);
        end
    endtask

    task automatic test_reset_abort;
        int pulses = 0;
        @(negedge clk);
        start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, div_by_zero, quotient, remainder} !== 19'd0) begin
            errors++;
            $display("FAIL abort_outputs busy=%b done=%b dbz=%b q=%0d r=%0d required all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        rst = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL abort_no_done pulses=%0d required 0", pulses);
        end
        test_case(8'd77, 8'd10, "after_abort_77_10");
    endtask

    task automatic test_back_to_back;
        int last = -1, pulses = 0, bad = 0;
        @(negedge clk);
        start = 1'b1; dividend = 8'd9; divisor = 8'd2;
        for (int n = 0; n < 45; n++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                if (quotient !== 8'd4 || remainder !== 8'd1) bad++;
                if (last >= 0 && n - last != 10) bad++;
                last = n;
            end
        end
        start = 1'b0;
        repeat (12) @(negedge clk);
        checks++;
        if (pulses < 4 || bad != 0) begin
            errors++;
            $display("FAIL back_to_back pulses=%0d bad=%0d required >=4 pulses, period 10, 4 r 1",
                     pulses, bad);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++) begin
            logic [7:0] a, b;
            a = 8'($urandom);
            b = (i % 8 == 3) ? 8'd0 : 8'($urandom_range(1, 255));
            test_case(a, b, "random");
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_start_ignored;
        test_reset_abort;
        test_back_to_back;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
